// File: rtl/clockworks_gearbox.sv
// Clock/reset front end: divides the board clock down to the core clock
// and turns the raw reset button into a clean core reset that is
// synchronous to that core clock.
`timescale 1ns/1ps

module clockworks_gearbox #(
    parameter int unsigned SLOW       = 21,
    parameter int unsigned RESET_HOLD = 15
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    // A RESET_HOLD of 0 would ask for a zero-width counter; keep one bit,
    // which then simply stays at its terminal value of 0.
    localparam int unsigned       HOLD_W   = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESET_HOLD);

    // ------------------------------------------------------------------
    // Divider. It is never reset so that holding the button cannot stop
    // the core clock; power-up state comes from the register initialiser.
    // ------------------------------------------------------------------
    generate
        if (SLOW == 0) begin : g_bypass
            assign clk = CLK;
        end else begin : g_div
            logic [SLOW-1:0] r_div = '0;

            // Free-running counter; its top bit is the 50% duty core clock.
            always_ff @(posedge CLK) begin
                r_div <= r_div + SLOW'(1);
            end

            assign clk = r_div[SLOW-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset path, entirely in the core clock domain.
    // ------------------------------------------------------------------
    logic [1:0]        r_sync   = 2'b11;
    logic [HOLD_W-1:0] r_hold   = '0;
    logic              r_resetn = 1'b0;
    logic              w_rst_s;

    assign w_rst_s = r_sync[1];

    // Two-flop synchroniser for the asynchronous button; powers up asserted.
    always_ff @(posedge clk) begin
        r_sync <= {r_sync[0], RESET};
    end

    // Count clean released cycles, re-arming from zero on any assertion.
    always_ff @(posedge clk) begin
        if (w_rst_s) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end

    // Registered core reset: released only once the hold time has elapsed.
    always_ff @(posedge clk) begin
        r_resetn <= (r_hold == HOLD_MAX) && !w_rst_s;
    end

    assign resetn = r_resetn;

endmodule

// File: tb/tb_clockworks_gearbox.sv
// Randomised self-checking bench for clockworks_gearbox: a divided instance
// (SLOW=2, RESET_HOLD=15) and a bypass instance (SLOW=0, RESET_HOLD=0)
// share one RESET stimulus and are compared against a behavioural model.
`timescale 1ns/1ps

module tb_clockworks_gearbox;

    localparam int unsigned SLOW_A = 2;
    localparam int unsigned HOLD_A = 15;
    localparam int unsigned HOLD_B = 0;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic clk_a, resetn_a;
    logic clk_b, resetn_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned n_clk   = 0;   // CLK rising edges since time zero
    int unsigned n_rise  = 0;   // clk_a rising edges since time zero
    int unsigned r0, r1;

    bit hist_a[$];              // RESET as seen at each clk_a rising edge
    bit hist_b[$];              // RESET as seen at each clk_b rising edge

    clockworks_gearbox #(.SLOW(SLOW_A), .RESET_HOLD(HOLD_A)) u_dut_a (
        .CLK    (CLK),
        .RESET  (RESET),
        .clk    (clk_a),
        .resetn (resetn_a)
    );

    clockworks_gearbox #(.SLOW(0), .RESET_HOLD(HOLD_B)) u_dut_b (
        .CLK    (CLK),
        .RESET  (RESET),
        .clk    (clk_b),
        .resetn (resetn_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Core reset is released after an edge only when the RESET samples taken
    // two edges earlier and the 'hold' samples before that were all low.
    // Samples from before the first edge count as asserted.
    function automatic logic exp_resetn(input bit h[$], input int unsigned hold);
        int k;
        k = h.size();
        for (int unsigned m = 0; m <= hold; m++) begin
            int i;
            i = k - 3 - int'(m);
            if (i < 0) return 1'b0;
            if (h[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Divider: clk is bit SLOW-1 of the number of CLK edges so far.
    always @(posedge CLK) begin
        n_clk++;
        #1;
        check("div_clk", {31'd0, clk_a}, ((n_clk % (1 << SLOW_A)) >> (SLOW_A - 1)) & 1);
        check("bypass_clk_hi", {31'd0, clk_b}, {31'd0, CLK});
    end

    always @(negedge CLK) begin
        #1;
        check("bypass_clk_lo", {31'd0, clk_b}, {31'd0, CLK});
    end

    // First core clock rises must land on CLK edges 2, 6, 10.
    always @(posedge clk_a) begin
        if (n_rise < 3) check("rise_edge", n_clk, 2 + 4 * n_rise);
        n_rise++;
    end

    always @(posedge clk_a) begin
        hist_a.push_back(RESET);
        #1;
        check("resetn_a", {31'd0, resetn_a}, {31'd0, exp_resetn(hist_a, HOLD_A)});
    end

    always @(posedge clk_b) begin
        hist_b.push_back(RESET);
        #1;
        check("resetn_b", {31'd0, resetn_b}, {31'd0, exp_resetn(hist_b, HOLD_B)});
    end

    task automatic wait_slow(input int unsigned n);
        repeat (n * (1 << SLOW_A)) @(negedge CLK);
    endtask

    initial begin
        #1;
        check("init_resetn_a", {31'd0, resetn_a}, 32'd0);
        check("init_resetn_b", {31'd0, resetn_b}, 32'd0);
        check("init_clk_a",    {31'd0, clk_a},    32'd0);
        @(negedge CLK);

        // Power-up with no press: release, then a long quiet stretch.
        wait_slow(140);

        // Press for five core periods, then release.
        RESET = 1'b1;
        wait_slow(5);
        RESET = 1'b0;
        wait_slow(30);

        // Bouncing button: toggles every core period.
        for (int i = 0; i < 10; i++) begin
            RESET = 1'b1;
            wait_slow(1);
            RESET = 1'b0;
            wait_slow(1);
        end
        wait_slow(30);

        // Held button: core clock must keep running.
        r0 = n_rise;
        RESET = 1'b1;
        wait_slow(25);
        r1 = n_rise;
        check("clk_runs_in_reset", r1 - r0, 25);
        RESET = 1'b0;
        wait_slow(30);

        // Random presses and glitches at board-clock granularity.
        for (int i = 0; i < 60; i++) begin
            RESET = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 40)) @(negedge CLK);
        end
        RESET = 1'b0;
        wait_slow(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
